// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: scales each signed PCM sample by an unsigned
// envelope driven through ATTACK/DECAY/SUSTAIN/RELEASE by a note gate.
// Optional: define ADSR_EXP_RELEASE_EN for an exponential release
// (decrement = (env >> RELEASE_SHIFT) + 1) instead of a linear release_step.
module adsr_envelope #(
  parameter int unsigned BIT_WIDTH     = 16,
  parameter int unsigned ENV_WIDTH     = 16,
  parameter int unsigned RELEASE_SHIFT = 6
) (
  input  logic                        clk_audio,
  input  logic                        reset,
  input  logic                        gate,
  input  logic signed [BIT_WIDTH-1:0] level_in,
  input  logic        [ENV_WIDTH-1:0] attack_step,
  input  logic        [ENV_WIDTH-1:0] decay_step,
  input  logic        [ENV_WIDTH-1:0] sustain_level,
  input  logic        [ENV_WIDTH-1:0] release_step,
  output logic signed [BIT_WIDTH-1:0] level_out,
  output logic        [ENV_WIDTH-1:0] envelope,
  output logic        [2:0]           state,
  output logic                        active
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  localparam logic [ENV_WIDTH-1:0] EnvMax  = '1;
  localparam logic [ENV_WIDTH:0]   EnvMaxX = {1'b0, EnvMax};

  state_e                        state_q, state_d;
  logic        [ENV_WIDTH-1:0]   env_q, env_d;
  logic signed [BIT_WIDTH-1:0]   level_q;

  logic        [ENV_WIDTH:0]     attack_sum, decay_diff, rel_dec, rel_diff;
  logic        [ENV_WIDTH-1:0]   attack_env, decay_env, release_env;
  logic signed [BIT_WIDTH+ENV_WIDTH:0] product;

  // Candidate envelope values for each phase, all computed one bit wide to catch wrap.
  always_comb begin
    attack_sum = {1'b0, env_q} + {1'b0, attack_step};
    attack_env = (attack_step == '0 || attack_sum >= EnvMaxX) ? EnvMax
                                                               : attack_sum[ENV_WIDTH-1:0];

    decay_diff = {1'b0, env_q} - {1'b0, decay_step};
    decay_env  = (decay_step == '0 || decay_diff[ENV_WIDTH] ||
                  decay_diff[ENV_WIDTH-1:0] <= sustain_level) ? sustain_level
                                                              : decay_diff[ENV_WIDTH-1:0];

`ifdef ADSR_EXP_RELEASE_EN
    // The +1 term guarantees the envelope reaches zero in finite time.
    rel_dec = {1'b0, env_q >> RELEASE_SHIFT} + {{ENV_WIDTH{1'b0}}, 1'b1};
`else
    // A zero step releases instantly.
    rel_dec = (release_step == '0) ? {1'b0, env_q} : {1'b0, release_step};
`endif
    rel_diff    = {1'b0, env_q} - rel_dec;
    release_env = rel_diff[ENV_WIDTH] ? '0 : rel_diff[ENV_WIDTH-1:0];
  end

  // Phase sequencing; a gate change wins over phase completion on the same edge.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    unique case (state_q)
      StIdle: begin
        env_d = '0;
        if (gate) begin
          state_d = StAttack;
          env_d   = attack_env;
        end
      end
      StAttack: begin
        if (!gate) begin
          state_d = StRelease;
          env_d   = release_env;
        end else begin
          env_d = attack_env;
          if (attack_env == EnvMax) state_d = StDecay;
        end
      end
      StDecay: begin
        if (!gate) begin
          state_d = StRelease;
          env_d   = release_env;
        end else begin
          env_d = decay_env;
          if (decay_env == sustain_level) state_d = StSustain;
        end
      end
      StSustain: begin
        if (!gate) begin
          state_d = StRelease;
          env_d   = release_env;
        end else begin
          env_d = sustain_level;
        end
      end
      StRelease: begin
        if (gate) begin
          // Retrigger from wherever the release has got to.
          state_d = StAttack;
          env_d   = attack_env;
        end else begin
          env_d = release_env;
          if (release_env == '0) state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        env_d   = '0;
      end
    endcase
  end

  // Signed sample times zero-extended envelope; shift keeps floor rounding.
  always_comb begin
    product = level_in * $signed({1'b0, env_q});
  end

  // State, envelope and output sample registers with synchronous reset.
  always_ff @(posedge clk_audio) begin
    if (reset) begin
      state_q <= StIdle;
      env_q   <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      level_q <= product[BIT_WIDTH+ENV_WIDTH-1:ENV_WIDTH];
    end
  end

  // Bits discarded by the fixed-point scaling, plus inputs unused in this build.
  logic unused_bits;
`ifdef ADSR_EXP_RELEASE_EN
  assign unused_bits = ^{product[ENV_WIDTH-1:0], product[BIT_WIDTH+ENV_WIDTH], release_step};
`else
  assign unused_bits = ^{product[ENV_WIDTH-1:0], product[BIT_WIDTH+ENV_WIDTH],
                         RELEASE_SHIFT[0]};
`endif

  assign level_out = level_q;
  assign envelope  = env_q;
  assign state     = state_q;
  assign active    = (state_q != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus a randomized
// run compared against an integer-arithmetic envelope model.
module tb_adsr_envelope;

  localparam int MAX = 65535;
  localparam int RS  = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               gate;
  logic signed [15:0] lvl;
  logic        [15:0] as_, ds, sl, rs;
  logic signed [15:0] level_out;
  logic        [15:0] envelope;
  logic        [2:0]  state;
  logic               active;

  int vec  = 0;
  int miss = 0;

  // Reference model: phase 0..4 = idle/attack/decay/sustain/release.
  int                 m_env;
  int                 m_ph;
  logic signed [15:0] m_out;

  adsr_envelope #(
    .BIT_WIDTH    (16),
    .ENV_WIDTH    (16),
    .RELEASE_SHIFT(RS)
  ) dut (
    .clk_audio    (clk),
    .reset        (rst),
    .gate         (gate),
    .level_in     (lvl),
    .attack_step  (as_),
    .decay_step   (ds),
    .sustain_level(sl),
    .release_step (rs),
    .level_out    (level_out),
    .envelope     (envelope),
    .state        (state),
    .active       (active)
  );

  always #5 clk = ~clk;

  function automatic int released(input int e);
    int dec;
`ifdef ADSR_EXP_RELEASE_EN
    dec = (e >> RS) + 1;
`else
    dec = (rs == 0) ? e : int'(rs);
`endif
    return (e - dec < 0) ? 0 : e - dec;
  endfunction

  function automatic int attacked(input int e);
    if (as_ == 0) return MAX;
    return (e + int'(as_) > MAX) ? MAX : e + int'(as_);
  endfunction

  task automatic model_step();
    longint p;
    if (rst) begin
      m_env = 0; m_ph = 0; m_out = '0;
      return;
    end
    p     = longint'(lvl) * longint'(m_env);
    m_out = 16'(p >>> 16);
    if (m_ph != 0 && m_ph != 4 && !gate) begin
      m_ph = 4; m_env = released(m_env);
    end else begin
      case (m_ph)
        0: if (gate) begin m_ph = 1; m_env = attacked(0); end
        1: begin m_env = attacked(m_env); if (m_env == MAX) m_ph = 2; end
        2: begin
          if (ds == 0 || m_env - int'(ds) <= int'(sl)) m_env = int'(sl);
          else m_env = m_env - int'(ds);
          if (m_env == int'(sl)) m_ph = 3;
        end
        3: m_env = int'(sl);
        default: begin
          if (gate) begin m_ph = 1; m_env = attacked(m_env); end
          else begin m_env = released(m_env); if (m_env == 0) m_ph = 0; end
        end
      endcase
    end
  endtask

  // Advance one sample: model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gate = 1'b1; lvl = 16'sh1234;
    tick();
    vec++; if (state !== 3'd0) begin miss++; $display("FAIL reset_state got %0d want 0", state); end
    vec++; if (envelope !== 16'h0) begin miss++; $display("FAIL reset_env got %h want 0", envelope); end
    vec++; if (level_out !== 16'sh0) begin miss++; $display("FAIL reset_out got %h want 0", level_out); end
    vec++; if (active !== 1'b0) begin miss++; $display("FAIL reset_active got %b want 0", active); end
  endtask

  task automatic test_scaling();
    rst = 1'b0; gate = 1'b1; as_ = 16'h0; ds = 16'h0; sl = 16'h8000; rs = 16'h1000;
    lvl = 16'sh4000;
    repeat (3) tick();
    vec++; if (envelope !== 16'h8000 || state !== 3'd3) begin
      miss++; $display("FAIL sustain_setup got env=%h st=%0d want env=8000 st=3", envelope, state);
    end
    tick();
    vec++; if (level_out !== 16'sh2000) begin miss++; $display("FAIL scale_half got %h want 2000", level_out); end
    lvl = -16'sd1;
    tick();
    vec++; if (level_out !== -16'sd1) begin miss++; $display("FAIL scale_neg_floor got %h want ffff", level_out); end
  endtask

  task automatic test_reset_mid_note();
    rst = 1'b1;
    tick();
    vec++; if (state !== 3'd0 || envelope !== 16'h0 || level_out !== 16'sh0 || active !== 1'b0) begin
      miss++; $display("FAIL midnote_reset got st=%0d env=%h out=%h act=%b want 0 0 0 0",
                       state, envelope, level_out, active);
    end
    rst = 1'b0;
    tick();
    vec++; if (state !== 3'd1 || envelope !== 16'hFFFF) begin
      miss++; $display("FAIL post_reset_attack got st=%0d env=%h want st=1 env=ffff", state, envelope);
    end
  endtask

  task automatic test_attack();
    logic [15:0] exp_env [4];
    logic [2:0]  exp_st  [4];
    exp_env = '{16'h5000, 16'hA000, 16'hF000, 16'hFFFF};
    exp_st  = '{3'd1, 3'd1, 3'd1, 3'd2};
    rst = 1'b1; tick(); rst = 1'b0;
    as_ = 16'h5000; ds = 16'h2000; sl = 16'hC000; gate = 1'b1; lvl = 16'sh7FFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if (envelope !== exp_env[i] || state !== exp_st[i]) begin
        miss++; $display("FAIL attack_%0d got env=%h st=%0d want env=%h st=%0d",
                         i, envelope, state, exp_env[i], exp_st[i]);
      end
    end
  endtask

  task automatic test_decay();
    tick();
    vec++; if (envelope !== 16'hDFFF || state !== 3'd2) begin
      miss++; $display("FAIL decay_step got env=%h st=%0d want dfff 2", envelope, state);
    end
    vec++; if (level_out !== 16'sh7FFE) begin miss++; $display("FAIL scale_full got %h want 7ffe", level_out); end
    tick();
    vec++; if (envelope !== 16'hC000 || state !== 3'd3) begin
      miss++; $display("FAIL decay_clamp got env=%h st=%0d want c000 3", envelope, state);
    end
    sl = 16'h4000;
    tick();
    vec++; if (envelope !== 16'h4000 || state !== 3'd3) begin
      miss++; $display("FAIL sustain_track got env=%h st=%0d want 4000 3", envelope, state);
    end
  endtask

  task automatic test_release();
    logic [15:0] exp_env [6];
    logic [2:0]  exp_st  [6];
    logic        gseq    [6];
    exp_env = '{16'h3000, 16'h2000, 16'h2100, 16'h1100, 16'h0100, 16'h0000};
    exp_st  = '{3'd4, 3'd4, 3'd1, 3'd4, 3'd4, 3'd0};
    gseq    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rs = 16'h1000; as_ = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      gate = gseq[i];
      tick();
      vec++; if (envelope !== m_env[15:0] || state !== m_ph[2:0]) begin
        miss++; $display("FAIL release_model_%0d got env=%h st=%0d want env=%h st=%0d",
                         i, envelope, state, m_env[15:0], m_ph[2:0]);
      end
`ifndef ADSR_EXP_RELEASE_EN
      vec++; if (envelope !== exp_env[i] || state !== exp_st[i]) begin
        miss++; $display("FAIL release_%0d got env=%h st=%0d want env=%h st=%0d",
                         i, envelope, state, exp_env[i], exp_st[i]);
      end
`endif
    end
    vec++; if (active !== (m_ph != 0)) begin
      miss++; $display("FAIL release_active got %b want %b", active, m_ph != 0);
    end
  endtask

`ifdef ADSR_EXP_RELEASE_EN
  task automatic test_exp_release();
    int n;
    rst = 1'b1; tick(); rst = 1'b0;
    gate = 1'b1; as_ = 16'h0; ds = 16'h0; sl = 16'h8000;
    repeat (3) tick();
    gate = 1'b0; rs = 16'h1234;
    tick();
    vec++; if (envelope !== 16'h7DFF || state !== 3'd4) begin
      miss++; $display("FAIL exp_first got env=%h st=%0d want 7dff 4", envelope, state);
    end
    n = 0;
    while (state != 3'd0 && n < 3000) begin
      rs = 16'($urandom);
      tick();
      n++;
      vec++; if (envelope !== m_env[15:0]) begin
        miss++; $display("FAIL exp_track got %h want %h", envelope, m_env[15:0]);
      end
    end
    vec++; if (state !== 3'd0 || envelope !== 16'h0) begin
      miss++; $display("FAIL exp_reach_idle got st=%0d env=%h want 0 0", state, envelope);
    end
  endtask
`endif

  function automatic logic [15:0] rnd_step();
    case ($urandom_range(0, 3))
      0:       return 16'h0;
      1:       return 16'($urandom_range(1, 255));
      2:       return 16'($urandom_range(256, 4095));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 24) == 0) gate = ~gate;
      if ($urandom_range(0, 39) == 0) as_ = rnd_step();
      if ($urandom_range(0, 39) == 0) ds  = rnd_step();
      if ($urandom_range(0, 39) == 0) rs  = rnd_step();
      if ($urandom_range(0, 59) == 0) sl  = 16'($urandom);
      lvl = 16'($urandom);
      tick();
      vec++; if (envelope !== m_env[15:0] || state !== m_ph[2:0] ||
                 level_out !== m_out || active !== (m_ph != 0)) begin
        miss++; $display("FAIL random_%0d got env=%h st=%0d out=%h act=%b want env=%h st=%0d out=%h act=%b",
                         i, envelope, state, level_out, active,
                         m_env[15:0], m_ph[2:0], m_out, m_ph != 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0; lvl = '0; as_ = '0; ds = '0; sl = '0; rs = '0;
    m_env = 0; m_ph = 0; m_out = '0;
    test_reset();
    test_scaling();
    test_reset_mid_note();
    test_attack();
    test_decay();
    test_release();
`ifdef ADSR_EXP_RELEASE_EN
    test_exp_release();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
